// File: rtl/result_tx_framer_if.sv
// result_tx_framer_if -- groups the result-side and byte-side signals of the
// result_tx_framer.
//   result / result_valid : 32-bit ALU result plus one-cycle qualifier
//   tx_byte / tx_byte_valid / tx_byte_ready : byte stream to the UART transmitter.
//     A byte moves on a rising edge where tx_byte_valid and tx_byte_ready are
//     both 1. While valid is high and ready is low, tx_byte is held. Valid never
//     depends combinationally on ready.
//   busy, frame_done, overflow / ovf_clr : status and sticky-error control
//   fsm_state : debug view of the framer state (0 IDLE, 1 HDR, 2 DATA, 3 CSUM)
// modport master : the framer side (drives the byte stream and status)
// modport slave  : the environment side (ALU, transmitter, controller)
interface result_tx_framer_if;
  logic [31:0] result;
  logic        result_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic        ovf_clr;
  logic [1:0]  fsm_state;

  modport master (
    input  result, result_valid, tx_byte_ready, ovf_clr,
    output tx_byte, tx_byte_valid, busy, frame_done, overflow, fsm_state
  );

  modport slave (
    output result, result_valid, tx_byte_ready, ovf_clr,
    input  tx_byte, tx_byte_valid, busy, frame_done, overflow, fsm_state
  );
endinterface

// File: rtl/result_tx_framer.sv
// result_tx_framer -- queues 32-bit ALU results in a small FIFO and sends each
// one as a 6-byte frame: HEADER, four data bytes MSB first, then the XOR of the
// four data bytes.
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : result_tx_framer_if.master (result input, byte stream, status)
module result_tx_framer #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  result_tx_framer_if.master  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t      state, state_n;

  // FIFO storage; pointers carry one extra bit so full and empty differ.
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        pop, push, xfer;

  logic [31:0] shreg;
  logic [7:0]  csum;
  logic [1:0]  idx;
  logic        frame_done_q;
  logic        overflow_q;
  logic [7:0]  tx_byte_c;
  logic        tx_valid_c;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The FSM only pops when leaving IDLE, so a pop frees a slot on the same
  // edge and a push into a full FIFO can still be taken then.
  assign pop  = (state == IDLE) && !fifo_empty;
  assign push = bus.result_valid && (!fifo_full || pop);
  assign xfer = tx_valid_c && bus.tx_byte_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and byte-stream outputs; valid comes from state only.
  always_comb begin
    state_n    = state;
    tx_byte_c  = 8'h00;
    tx_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_n = HDR;
      end
      HDR: begin
        tx_byte_c  = HEADER;
        tx_valid_c = 1'b1;
        if (bus.tx_byte_ready) state_n = DATA;
      end
      DATA: begin
        tx_byte_c  = shreg[31:24];
        tx_valid_c = 1'b1;
        if (bus.tx_byte_ready && (idx == 2'd3)) state_n = CSUM;
      end
      CSUM: begin
        tx_byte_c  = csum;
        tx_valid_c = 1'b1;
        if (bus.tx_byte_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr[AW-1:0]] <= bus.result;
  end

  // Frame datapath and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      csum         <= '0;
      idx          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= (state == CSUM) && xfer;

      // A new drop wins over a clear in the same cycle.
      if (bus.result_valid && !push) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end

      if (pop) begin
        shreg <= mem[rd_ptr[AW-1:0]];
        csum  <= 8'h00;
        idx   <= 2'd0;
      end else if ((state == DATA) && xfer) begin
        csum  <= csum ^ shreg[31:24];
        shreg <= {shreg[23:0], 8'h00};
        idx   <= idx + 2'd1;
      end
    end
  end

  assign bus.tx_byte       = tx_byte_c;
  assign bus.tx_byte_valid = tx_valid_c;
  assign bus.busy          = (state != IDLE) || !fifo_empty;
  assign bus.frame_done    = frame_done_q;
  assign bus.overflow      = overflow_q;
  assign bus.fsm_state     = state;

endmodule
